// File: rtl/uart_paket_tx.sv
// -----------------------------------------------------------------------------
// uart_paket_tx
//
// Serial packet transmitter. On an accepted start request it latches a 128-bit
// payload and sends a 20-byte frame over one 8N1 UART line:
//   header[15:8], header[7:0], payload bytes MSB-first, sum[15:8], sum[7:0]
// where sum is the 16-bit wrap-around sum of the 16 payload bytes.
//
// Ports:
//   clk      - system clock, everything on the rising edge
//   rst      - synchronous active-high reset, aborts a frame immediately
//   send     - start request, honoured only while idle
//   data_in  - 128-bit payload, sampled in the cycle send is accepted
//   data_out - serial line, idle high, registered
//   busy     - high while a frame is in progress, registered
//   done     - one-cycle pulse when the last stop bit of a frame completes
// -----------------------------------------------------------------------------
module uart_paket_tx #(
  parameter int unsigned clk_freq  = 100_000_000,
  parameter int unsigned baud_rate = 115_200,
  parameter logic [15:0] baslik    = 16'hA55A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send,
  input  logic [127:0] data_in,
  output logic         data_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned clks_per_bit = clk_freq / baud_rate;
  localparam int unsigned cnt_w        = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [cnt_w-1:0] baud_last = cnt_w'(clks_per_bit - 1);
  localparam logic [4:0]       last_byte = 5'd19;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [4:0]         byte_idx_q, byte_idx_d;
  logic [127:0]       payload_q, payload_d;
  logic [7:0]         shift_q, shift_d;
  logic               data_out_q, data_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        sum_w;

  // Wrap-around sum of the 16 zero-extended payload bytes.
  function automatic logic [15:0] payload_sum(input logic [127:0] p);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + {8'h00, p[8*i +: 8]};
    end
    return acc;
  endfunction

  // Byte number idx of the frame (idx 0 is loaded directly on acceptance).
  function automatic logic [7:0] frame_byte(input logic [4:0]   idx,
                                            input logic [127:0] p,
                                            input logic [15:0]  s);
    logic [7:0] b;
    b = baslik[15:8];
    if (idx == 5'd1) b = baslik[7:0];
    for (int i = 0; i < 16; i++) begin
      if (idx == 5'(i + 2)) b = p[127 - 8*i -: 8];
    end
    if (idx == 5'd18) b = s[15:8];
    if (idx == 5'd19) b = s[7:0];
    return b;
  endfunction

  assign sum_w = payload_sum(payload_q);

  // Next-state logic. Output values are computed for the state being entered
  // so the registered outputs change on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    payload_d  = payload_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        data_out_d = 1'b1;
        busy_d     = 1'b0;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        byte_idx_d = '0;
        if (send) begin
          payload_d  = data_in;
          shift_d    = baslik[15:8];
          state_d    = START;
          data_out_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (baud_cnt_q == baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
          data_out_d = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + cnt_w'(1);
        end
      end

      DATA: begin
        if (baud_cnt_q == baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d    = STOP;
            data_out_d = 1'b1;
          end else begin
            bit_idx_d  = bit_idx_q + 3'd1;
            data_out_d = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + cnt_w'(1);
        end
      end

      STOP: begin
        if (baud_cnt_q == baud_last) begin
          baud_cnt_d = '0;
          if (byte_idx_q < last_byte) begin
            // Back-to-back bytes: next start bit follows the stop bit directly.
            byte_idx_d = byte_idx_q + 5'd1;
            shift_d    = frame_byte(byte_idx_q + 5'd1, payload_q, sum_w);
            state_d    = START;
            data_out_d = 1'b0;
          end else begin
            // Byte index stays at its final value until IDLE clears it.
            done_d     = 1'b1;
            busy_d     = 1'b0;
            data_out_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + cnt_w'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        data_out_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      payload_q  <= '0;
      shift_q    <= '0;
      data_out_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      payload_q  <= payload_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_paket_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_paket_tx
//
// Scoreboard bench for uart_paket_tx at 16 clocks per bit. The stimulus side
// pushes the bytes each accepted frame should carry; an independent UART
// decoder pops and compares them as it receives bytes off the line, and also
// checks bit widths, stop bits, frame length and the done pulse.
// -----------------------------------------------------------------------------
module tb_uart_paket_tx;

  localparam int          CPB       = 16;
  localparam int          BYTE_CYC  = 10 * CPB;
  localparam int          FRAME_CYC = 20 * BYTE_CYC;
  localparam logic [15:0] BASLIK    = 16'hA55A;

  logic         clk;
  logic         rst;
  logic         send;
  logic [127:0] data_in;
  logic         data_out;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  int cyc;

  logic [7:0] exp_q[$];

  uart_paket_tx #(
    .clk_freq (16),
    .baud_rate(1),
    .baslik   (BASLIK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .data_in (data_in),
    .data_out(data_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare and report one value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Reference model: the 20 bytes a frame for payload p must carry.
  task automatic pushFrame(input logic [127:0] p);
    int s;
    logic [7:0] b;
    s = 0;
    exp_q.push_back(BASLIK[15:8]);
    exp_q.push_back(BASLIK[7:0]);
    for (int i = 15; i >= 0; i--) begin
      b = p[8*i +: 8];
      exp_q.push_back(b);
      s = s + int'(b);
    end
    s = s % 65536;
    exp_q.push_back(8'(s / 256));
    exp_q.push_back(8'(s % 256));
  endtask

  // Pulse send for one cycle with payload p and record its expected frame.
  task automatic applyStimulus(input logic [127:0] p);
    @(posedge clk);
    #1;
    send    = 1'b1;
    data_in = p;
    pushFrame(p);
    @(posedge clk);
    #1;
    send    = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Wait for a done pulse, bounded by a cycle budget.
  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout actual=no_done expected=done within %0d cycles", budget);
    end
  endtask

  function automatic logic [127:0] randPayload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // UART decoder / scoreboard monitor, sampling on the falling edge.
  int         mon_k;
  int         mon_byte_cnt;
  int         mon_frame_start;
  bit         mon_active;
  bit         mon_expect_done;
  bit         mon_expect_start;
  logic       mon_slot_val;
  logic [7:0] mon_bits;

  always @(negedge clk) begin
    int slot;
    int off;
    cyc++;
    if (rst) begin
      mon_active       = 1'b0;
      mon_k            = 0;
      mon_byte_cnt     = 0;
      mon_expect_done  = 1'b0;
      mon_expect_start = 1'b0;
    end else begin
      if (mon_expect_done) begin
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("line_at_done", 32'(data_out), 32'd1);
        checkOutput("frame_cycles", 32'(cyc - mon_frame_start), 32'(FRAME_CYC));
        mon_expect_done = 1'b0;
      end else if (done) begin
        checkOutput("done_unexpected", 32'(done), 32'd0);
      end

      if (mon_expect_start) begin
        checkOutput("byte_gap", 32'(data_out), 32'd0);
        mon_expect_start = 1'b0;
      end

      if (!mon_active && data_out == 1'b0) begin
        mon_active = 1'b1;
        mon_k      = 0;
        if (mon_byte_cnt == 0) mon_frame_start = cyc;
      end

      if (mon_active) begin
        slot = mon_k / CPB;
        off  = mon_k % CPB;
        if (off == 0) begin
          mon_slot_val = data_out;
          if (slot >= 1 && slot <= 8) mon_bits[slot-1] = data_out;
          if (slot == 9) checkOutput("stop_bit", 32'(data_out), 32'd1);
        end else if (data_out !== mon_slot_val) begin
          checkOutput("bit_width", 32'(data_out), 32'(mon_slot_val));
        end
        mon_k++;
        if (mon_k == BYTE_CYC) begin
          checkOutput("busy_in_frame", 32'(busy), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte actual=%0h expected=none", mon_bits);
          end else begin
            checkOutput("frame_byte", 32'(mon_bits), 32'(exp_q.pop_front()));
          end
          mon_active = 1'b0;
          mon_byte_cnt++;
          if (mon_byte_cnt == 20) begin
            mon_byte_cnt    = 0;
            mon_expect_done = 1'b1;
          end else begin
            mon_expect_start = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] p1;
    logic [127:0] p2;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b1;
    send    = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle line after reset.
    repeat (50) begin
      @(negedge clk);
      checkOutput("idle_line", 32'(data_out), 32'd1);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
    end

    $display("[TB] directed frame");
    applyStimulus(128'h00112233445566778899AABBCCDDEEFF);
    waitDone(FRAME_CYC + 100);

    $display("[TB] all-ones and all-zeros payloads");
    applyStimulus({128{1'b1}});
    waitDone(FRAME_CYC + 100);
    applyStimulus('0);
    waitDone(FRAME_CYC + 100);

    $display("[TB] send while busy");
    applyStimulus(randPayload());
    repeat (5 * BYTE_CYC + 40) @(posedge clk);
    #1;
    send    = 1'b1;
    data_in = randPayload();
    @(posedge clk);
    #1;
    send = 1'b0;
    waitDone(FRAME_CYC + 100);
    repeat (400) @(negedge clk);
    checkOutput("no_second_frame", 32'(exp_q.size()), 32'd0);
    checkOutput("line_idle_after", 32'(data_out), 32'd1);

    $display("[TB] back-to-back frames");
    p1 = randPayload();
    p2 = randPayload();
    @(posedge clk);
    #1;
    send    = 1'b1;
    data_in = p1;
    pushFrame(p1);
    waitDone(FRAME_CYC + 100);
    data_in = p2;
    pushFrame(p2);
    @(negedge clk);
    checkOutput("b2b_start_bit", 32'(data_out), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    send    = 1'b0;
    data_in = randPayload();
    waitDone(FRAME_CYC + 100);
    repeat (10) @(negedge clk);
    checkOutput("b2b_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset during byte 10");
    applyStimulus(randPayload());
    repeat (10 * BYTE_CYC + 60) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_line", 32'(data_out), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (300) @(negedge clk);
    applyStimulus(randPayload());
    waitDone(FRAME_CYC + 100);

    $display("[TB] random frames");
    repeat (2) begin
      applyStimulus(randPayload());
      waitDone(FRAME_CYC + 100);
    end

    repeat (20) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
